// File: rtl/dsp_dot_product_ctrl.sv
// Dot-product sequencer for a DSP48A1 slice. Operand pairs from the input
// stream are fed to the DSP; gaps in the stream become zero-product bubbles
// so the DSP pipeline never stalls. The accumulated P is captured once the
// last product has drained through the slice.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; len sampled here
// S_ACCUM | accepting operand pairs until the pair counter hits 0
// S_DRAIN | LATENCY cycles for the last product to reach dsp_p
// S_DONE  | res_valid held with stable res_data until res_ready
module dsp_dot_product_ctrl #(
   parameter int LATENCY = 4,
   parameter int OPM_DLY = 1,
   parameter int LEN_W   = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [LEN_W-1:0]    len,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [17:0]  in_a,
   input  logic signed [17:0]  in_b,
   output logic [17:0]         dsp_a,
   output logic [17:0]         dsp_b,
   output logic [17:0]         dsp_d,
   output logic [47:0]         dsp_c,
   output logic [7:0]          dsp_opmode,
   output logic                dsp_ce,
   output logic                dsp_rst,
   input  logic [47:0]         dsp_p,
   output logic                res_valid,
   input  logic                res_ready,
   output logic signed [47:0]  res_data,
   output logic                busy
);

   localparam int DRN_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   // X=M, Z=0: first product of a run restarts the accumulator
   localparam logic [7:0] OPM_FIRST = 8'b0000_0001;
   // X=M, Z=P: accumulate onto the running sum
   localparam logic [7:0] OPM_ACC   = 8'b0000_1001;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [LEN_W-1:0]   pair_cnt;
   logic [DRN_W-1:0]   drain_cnt;
   logic               first_seen;
   logic               accept;
   logic [7:0]         opm_pipe [0:OPM_DLY];

   assign dsp_d      = '0;
   assign dsp_c      = '0;
   assign dsp_ce     = 1'b1;
   assign dsp_rst    = rst;
   assign dsp_opmode = opm_pipe[OPM_DLY];

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state decode and state-derived handshake outputs
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      res_valid = 1'b0;
      busy      = 1'b1;
      accept    = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_d = (len == '0) ? S_DONE : S_ACCUM;
         end
         S_ACCUM: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (in_valid && pair_cnt == LEN_W'(1)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (drain_cnt == '0) state_d = S_DONE;
         end
         S_DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Pair counter, drain timer, result capture and first-pair tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         pair_cnt   <= '0;
         drain_cnt  <= '0;
         res_data   <= '0;
         first_seen <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  pair_cnt   <= len;
                  first_seen <= 1'b0;
                  if (len == '0) res_data <= '0;
               end
            end
            S_ACCUM: begin
               if (accept) begin
                  pair_cnt   <= pair_cnt - LEN_W'(1);
                  first_seen <= 1'b1;
                  if (pair_cnt == LEN_W'(1)) drain_cnt <= DRN_W'(LATENCY - 1);
               end
            end
            S_DRAIN: begin
               if (drain_cnt == '0) res_data <= $signed(dsp_p);
               else                 drain_cnt <= drain_cnt - DRN_W'(1);
            end
            default: ;
         endcase
      end
   end

   // DSP operand register: accepted pair or a zero bubble every cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         dsp_a <= '0;
         dsp_b <= '0;
      end else begin
         dsp_a <= accept ? in_a : '0;
         dsp_b <= accept ? in_b : '0;
      end
   end

   // Opmode delay line: stage 0 aligns with dsp_a, stage OPM_DLY drives the DSP.
   // Bubbles ahead of the first pair also clear Z so nothing leaks from a prior run.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i <= OPM_DLY; i++) opm_pipe[i] <= '0;
      end else begin
         opm_pipe[0] <= first_seen ? OPM_ACC : OPM_FIRST;
         for (int i = 1; i <= OPM_DLY; i++) opm_pipe[i] <= opm_pipe[i-1];
      end
   end

endmodule

// File: tb/tb_dsp_dot_product_ctrl.sv
module tb_dsp_dot_product_ctrl;

   localparam int LATENCY = 4;
   localparam int OPM_DLY = 1;
   localparam int LEN_W   = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic [LEN_W-1:0]   len;
   logic               in_valid;
   logic               in_ready;
   logic signed [17:0] in_a;
   logic signed [17:0] in_b;
   logic [17:0]        dsp_a;
   logic [17:0]        dsp_b;
   logic [17:0]        dsp_d;
   logic [47:0]        dsp_c;
   logic [7:0]         dsp_opmode;
   logic               dsp_ce;
   logic               dsp_rst;
   logic [47:0]        dsp_p;
   logic               res_valid;
   logic               res_ready;
   logic signed [47:0] res_data;
   logic               busy;

   int n_checks = 0;
   int n_fail   = 0;

   dsp_dot_product_ctrl #(.LATENCY(LATENCY), .OPM_DLY(OPM_DLY), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_c(dsp_c),
      .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce), .dsp_rst(dsp_rst), .dsp_p(dsp_p),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
   );

   always #5 clk = ~clk;

   // DSP48A1 behavioural model: B/A reg, M reg, P reg (LATENCY-1 stages past dsp_a),
   // opmode registered once so it meets its product at the P stage.
   logic signed [35:0] ab_r, m_r;
   logic [7:0]         op_r;
   logic [47:0]        p_r;
   assign dsp_p = p_r;

   always @(posedge clk) begin
      if (dsp_rst) begin
         ab_r <= '0; m_r <= '0; op_r <= '0; p_r <= '0;
      end else begin
         ab_r <= $signed(dsp_a) * $signed(dsp_b);
         m_r  <= ab_r;
         op_r <= dsp_opmode;
         p_r  <= (op_r[3] ? p_r : 48'd0) + {{12{m_r[35]}}, m_r};
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int n);
      start = 1'b1;
      len   = n[LEN_W-1:0];
      cyc();
      start = 1'b0;
   endtask

   task automatic send(input int a, input int b);
      in_valid = 1'b1;
      in_a     = a[17:0];
      in_b     = b[17:0];
      cyc();
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
   endtask

   // edges after the current point until res_valid is seen; -1 if the bound expires
   task automatic wait_valid(input int max, output int edges);
      int n = 0;
      while (res_valid !== 1'b1 && n < max) begin
         cyc();
         n++;
      end
      edges = (res_valid === 1'b1) ? n : -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc();
      cyc();
      n_checks++; if (dsp_rst !== 1'b1) begin n_fail++; $display("FAIL reset_dsp_rst: got %0h want 1", dsp_rst); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h want 0", busy); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0h want 0", in_ready); end
      n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %0h want 0", res_valid); end
      n_checks++; if (res_data !== 48'd0) begin n_fail++; $display("FAIL reset_res_data: got %0h want 0", res_data); end
      n_checks++; if (dsp_a !== 18'd0 || dsp_b !== 18'd0) begin n_fail++; $display("FAIL reset_dsp_ab: got %0h/%0h want 0/0", dsp_a, dsp_b); end
      n_checks++; if (dsp_opmode !== 8'h00) begin n_fail++; $display("FAIL reset_opmode: got %0h want 0", dsp_opmode); end
      n_checks++; if (dsp_ce !== 1'b1) begin n_fail++; $display("FAIL reset_dsp_ce: got %0h want 1", dsp_ce); end
      n_checks++; if (dsp_c !== 48'd0 || dsp_d !== 18'd0) begin n_fail++; $display("FAIL reset_dsp_cd: got %0h/%0h want 0/0", dsp_c, dsp_d); end
      rst = 1'b0;
      #1;
      n_checks++; if (dsp_rst !== 1'b0) begin n_fail++; $display("FAIL release_dsp_rst: got %0h want 0", dsp_rst); end
      cyc();
   endtask

   task automatic test_basic();
      bit early = 0;
      do_start(3);
      n_checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_accum_flags: got rdy=%0h busy=%0h want 1/1", in_ready, busy); end
      in_valid = 1'b1; in_a = 18'sd2; in_b = 18'sd3;
      cyc();
      n_checks++; if (dsp_a !== 18'd2 || dsp_b !== 18'd3) begin n_fail++; $display("FAIL basic_dsp_ab: got %0h/%0h want 2/3", dsp_a, dsp_b); end
      n_checks++; if (dsp_opmode !== 8'h01) begin n_fail++; $display("FAIL basic_opm_bubble: got %0h want 01", dsp_opmode); end
      in_a = 18'sd4; in_b = 18'sd5;
      cyc();
      n_checks++; if (dsp_opmode !== 8'h01) begin n_fail++; $display("FAIL basic_opm_first: got %0h want 01", dsp_opmode); end
      in_a = -18'sd1; in_b = 18'sd7;
      cyc();
      in_valid = 1'b0; in_a = '0; in_b = '0;
      n_checks++; if (dsp_opmode !== 8'h09) begin n_fail++; $display("FAIL basic_opm_acc: got %0h want 09", dsp_opmode); end
      n_checks++; if (dsp_a !== 18'h3FFFF) begin n_fail++; $display("FAIL basic_dsp_a_neg: got %0h want 3ffff", dsp_a); end
      n_checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_drain_flags: got rdy=%0h busy=%0h want 0/1", in_ready, busy); end
      for (int j = 1; j < LATENCY; j++) begin
         cyc();
         if (res_valid !== 1'b0) early = 1;
      end
      n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %0h want 0", early); end
      cyc();
      n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_timing: got %0h want 1", res_valid); end
      n_checks++; if (res_data !== 48'sd19) begin n_fail++; $display("FAIL basic_res_data: got %0d want 19", res_data); end
      cyc();
      n_checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_return_idle: got v=%0h busy=%0h want 0/0", res_valid, busy); end
   endtask

   task automatic test_bubbles();
      bit bad = 0;
      int e;
      do_start(2);
      send(100, -3);
      for (int j = 0; j < 5; j++) begin
         cyc();
         if (dsp_a !== 18'd0 || dsp_b !== 18'd0 || in_ready !== 1'b1) bad = 1;
      end
      n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL bubbles_zero_operands: got %0h want 0", bad); end
      send(7, 7);
      wait_valid(LATENCY + 4, e);
      n_checks++; if (e !== LATENCY) begin n_fail++; $display("FAIL bubbles_latency: got %0d want %0d", e, LATENCY); end
      n_checks++; if (res_data !== 48'hFFFF_FFFF_FF05) begin n_fail++; $display("FAIL bubbles_res_data: got %0h want ffffffffff05", res_data); end
      cyc();
   endtask

   task automatic test_len_zero();
      do_start(0);
      n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL len0_valid: got %0h want 1", res_valid); end
      n_checks++; if (res_data !== 48'd0) begin n_fail++; $display("FAIL len0_res_data: got %0h want 0", res_data); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL len0_in_ready: got %0h want 0", in_ready); end
      cyc();
      n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL len0_return: got busy=%0h rdy=%0h v=%0h want 0/0/0", busy, in_ready, res_valid); end
   endtask

   task automatic test_backpressure();
      bit stable = 1;
      int e;
      res_ready = 1'b0;
      do_start(1);
      send(5, 6);
      wait_valid(LATENCY + 4, e);
      n_checks++; if (e !== LATENCY) begin n_fail++; $display("FAIL bp_latency: got %0d want %0d", e, LATENCY); end
      n_checks++; if (res_data !== 48'sd30) begin n_fail++; $display("FAIL bp_res_data: got %0d want 30", res_data); end
      for (int k = 0; k < 10; k++) begin
         if (k == 3) begin start = 1'b1; len = 8'd2; end
         cyc();
         start = 1'b0;
         if (res_valid !== 1'b1 || res_data !== 48'sd30 || in_ready !== 1'b0) stable = 0;
      end
      n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_hold_stable: got %0h want 1", stable); end
      res_ready = 1'b1;
      cyc();
      n_checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_return_idle: got busy=%0h v=%0h want 0/0", busy, res_valid); end
      cyc();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_start_ignored: got busy=%0h want 0", busy); end
   endtask

   task automatic test_reset_mid_run();
      bit pulse = 0;
      int e;
      do_start(3);
      send(1, 2);
      rst = 1'b1;
      #1;
      n_checks++; if (dsp_rst !== 1'b1) begin n_fail++; $display("FAIL midrst_dsp_rst: got %0h want 1", dsp_rst); end
      cyc();
      rst = 1'b0;
      n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got busy=%0h rdy=%0h v=%0h want 0/0/0", busy, in_ready, res_valid); end
      n_checks++; if (res_data !== 48'd0) begin n_fail++; $display("FAIL midrst_res_data: got %0h want 0", res_data); end
      n_checks++; if (dsp_a !== 18'd0 || dsp_b !== 18'd0 || dsp_opmode !== 8'h00) begin n_fail++; $display("FAIL midrst_dsp: got a=%0h b=%0h op=%0h want 0/0/0", dsp_a, dsp_b, dsp_opmode); end
      for (int j = 0; j < 8; j++) begin
         cyc();
         if (res_valid !== 1'b0 || busy !== 1'b0) pulse = 1;
      end
      n_checks++; if (pulse !== 1'b0) begin n_fail++; $display("FAIL midrst_aborted: got %0h want 0", pulse); end
      do_start(1);
      send(3, 3);
      wait_valid(LATENCY + 4, e);
      n_checks++; if (e !== LATENCY || res_data !== 48'sd9) begin n_fail++; $display("FAIL midrst_rerun: got lat=%0d data=%0d want %0d/9", e, res_data, LATENCY); end
      cyc();
   endtask

   task automatic test_min_max();
      int e;
      do_start(1);
      send(-131072, 131071);
      wait_valid(LATENCY + 4, e);
      n_checks++; if (e !== LATENCY) begin n_fail++; $display("FAIL minmax_latency: got %0d want %0d", e, LATENCY); end
      n_checks++; if (res_data !== 48'hFFFC_0002_0000) begin n_fail++; $display("FAIL minmax_res_data: got %0h want fffc00020000", res_data); end
      cyc();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL minmax_return: got busy=%0h want 0", busy); end
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      len       = '0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      res_ready = 1'b1;
      test_reset();
      test_basic();
      test_bubbles();
      test_len_zero();
      test_backpressure();
      test_reset_mid_run();
      test_min_max();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
